store_narrow: RTL and testbench
===============================

STORE_NARROW -- requirements
Module: Store_Narrow

Interface
REQ-001 Parameter BIG_ENDIAN, default 0, selects byte-lane mapping: 0 = little-endian, 1 = big-endian.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  1  store request valid.
REQ-005 ready_o  output  1  block can accept a request.
REQ-006 addr_i  input  32  byte address of store.
REQ-007 size_i  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 wdata_i  input  32  register data; narrowed to size_i.
REQ-009 mem_addr_o  output  32  word address to memory, bits [1:0] always 0.
REQ-010 mem_re_o  output  1  memory read strobe; data returns on mem_rdata_i one cycle later.
REQ-011 mem_rdata_i  input  32  memory read data.
REQ-012 mem_we_o  output  1  memory full-word write strobe.
REQ-013 mem_wdata_o  output  32  merged word to write.
REQ-014 done_o  output  1  one-cycle pulse: store complete.
REQ-015 err_o  output  1  one-cycle pulse: store rejected (misaligned or illegal size).

Function
REQ-016 Handshake: request accepted on a rising edge with req_i=1 and ready_o=1; ready_o shall be 1 only in IDLE.
REQ-017 addr_i, size_i and wdata_i shall be registered at acceptance; later input changes shall have no effect on that store.
REQ-018 FSM states: IDLE, RD, MERGE, WR, ERR.
REQ-019 IDLE->WR on accepted aligned word; IDLE->RD on accepted aligned byte/halfword; IDLE->ERR on accepted misaligned or illegal request; otherwise stay in IDLE.
REQ-020 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00; size 11 is always illegal.
REQ-021 RD: mem_re_o=1, mem_addr_o={addr[31:2],2'b00}; next state MERGE.
REQ-022 MERGE: capture mem_rdata_i, replace only the target lane(s), keep all other bytes unchanged; next state WR.
REQ-023 WR: mem_we_o=1, mem_addr_o=word address, mem_wdata_o=merged word (or wdata_i unchanged for a word store), done_o=1; next state IDLE.
REQ-024 ERR: err_o=1; no memory strobes; next state IDLE.
REQ-025 Narrowing: byte uses wdata[7:0] only; halfword uses wdata[15:0] only; upper bits are discarded without checks.
REQ-026 Little-endian lanes: byte k = addr[1:0] occupies bits [8k+7:8k]; halfword at addr[1]=0 occupies [15:0], at addr[1]=1 occupies [31:16].
REQ-027 Big-endian lanes: byte k occupies bits [31-8k:24-8k]; halfword at addr[1]=0 occupies [31:16], at addr[1]=1 occupies [15:0].
REQ-028 Latency from the acceptance edge: word, done_o in the next cycle; byte/halfword, done_o in the third cycle; error, err_o in the next cycle.
REQ-029 mem_re_o and mem_we_o shall never both be 1; done_o and err_o shall never both be 1.
REQ-030 Outside RD and WR, mem_re_o and mem_we_o shall be 0; mem_addr_o and mem_wdata_o values are don't-care there.
REQ-031 A request arriving while busy is not accepted; req_i must be held until ready_o=1.
REQ-032 Back-to-back: a request presented in the cycle the FSM returns to IDLE is accepted on that edge; no idle bubble beyond the IDLE cycle itself.

Reset
REQ-033 rst_n=0 shall immediately force: state IDLE, ready_o=1, mem_re_o=0, mem_we_o=0, done_o=0, err_o=0, mem_addr_o=0, mem_wdata_o=0, captured registers=0.
REQ-034 Reset asserted mid-store aborts the store: no write is issued after reset releases and no done_o pulse follows.

Verification
REQ-035 Word store addr=0x100, wdata=0xDEADBEEF -> next cycle mem_we_o=1, mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF, done_o=1; mem_re_o never asserted.
REQ-036 LE byte store addr=0x203, wdata=0x123456AB, memory holds 0x11223344 -> RD at 0x200, then WR mem_wdata_o=0xAB223344, done_o on the third cycle.
REQ-037 LE halfword store addr=0x302, wdata=0xFFFFCAFE, memory holds 0x11223344 -> mem_wdata_o=0xCAFE3344; with BIG_ENDIAN=1 -> 0x1122CAFE.
REQ-038 Halfword addr=0x101, word addr=0x102, and size=11 -> err_o pulse one cycle after acceptance each; mem_re_o and mem_we_o stay 0.
REQ-039 Assert rst_n=0 during MERGE of a byte store, release after 2 cycles -> ready_o=1, no mem_we_o and no done_o after release.
REQ-040 Two byte stores back-to-back with req_i held high -> second accepted in the IDLE cycle after the first WR; each completes with correct merged data.

Source files
------------

// File: rtl/store_narrow.sv
// store_narrow: narrows a byte/halfword/word store into a full-word memory
// write, using read-modify-write for sub-word stores. Misaligned or
// illegal-size requests are rejected with a one-cycle error pulse.
module store_narrow #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        ready_o,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;

  logic        accept;
  logic        bad_req;
  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged_nxt;
  logic [31:0] word_addr;

  assign accept    = req_i && (state == IDLE);
  assign word_addr = {addr_q[31:2], 2'b00};

  // Classify the incoming request as misaligned or illegal size.
  always_comb begin
    bad_req = 1'b0;
    case (size_i)
      SZ_BYTE: bad_req = 1'b0;
      SZ_HALF: bad_req = addr_i[0];
      SZ_WORD: bad_req = (addr_i[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the request at acceptance and the merged word at the end of MERGE.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr_i;
        size_q  <= size_i;
        wdata_q <= wdata_i;
      end
      if (state == MERGE) begin
        merged_q <= merged_nxt;
      end
    end
  end

  // Lane selection: data is replicated across all lanes and a byte mask picks
  // the target lane(s); big-endian mirrors the byte index (k -> 3-k).
  always_comb begin
    byte_lane = addr_q[1:0] ^ {2{BIG_ENDIAN}};
    half_hi   = addr_q[1] ^ BIG_ENDIAN;
    lane_mask = '0;
    lane_data = '0;
    case (size_q)
      SZ_BYTE: begin
        lane_mask = 4'b0001 << byte_lane;
        lane_data = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        lane_mask = half_hi ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = '1;
        lane_data = wdata_q;
      end
    endcase
  end

  // Replace the selected lanes of the read word, keep the others.
  always_comb begin
    merged_nxt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      merged_nxt[8*i +: 8] = lane_mask[i] ? lane_data[8*i +: 8] : mem_rdata_i[8*i +: 8];
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_nxt   = state;
    ready_o     = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          if (bad_req) begin
            state_nxt = ERR;
          end else if (size_i == SZ_WORD) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        mem_re_o   = 1'b1;
        mem_addr_o = word_addr;
        state_nxt  = MERGE;
      end
      MERGE: begin
        state_nxt = WR;
      end
      WR: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = word_addr;
        mem_wdata_o = (size_q == SZ_WORD) ? wdata_q : merged_q;
        done_o      = 1'b1;
        state_nxt   = IDLE;
      end
      ERR: begin
        err_o     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_store_narrow.sv
// Testbench for store_narrow: little- and big-endian instances share the
// request stream; each has its own memory model, checked against a
// lane-arithmetic reference with its own memory image.
module tb_store_narrow;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;

  logic        rdy_le, re_le, we_le, done_le, err_le;
  logic [31:0] maddr_le, wd_le, rdata_le;
  logic        rdy_be, re_be, we_be, done_be, err_be;
  logic [31:0] maddr_be, wd_be, rdata_be;

  logic [31:0] dmem_le [256];
  logic [31:0] dmem_be [256];
  logic [31:0] rmem_le [256];
  logic [31:0] rmem_be [256];

  logic [31:0] last_le, last_be;

  int checks   = 0;
  int failures = 0;

  localparam int N = 40;
  logic [31:0] ra  [N];
  logic [1:0]  rs  [N];
  logic [31:0] rd  [N];
  bit          rb2b[N];

  store_narrow #(.BIG_ENDIAN(1'b0)) u_le (
    .clk_i(clk), .rst_n(rst_n), .req_i(req), .ready_o(rdy_le),
    .addr_i(addr), .size_i(size), .wdata_i(wdata),
    .mem_addr_o(maddr_le), .mem_re_o(re_le), .mem_rdata_i(rdata_le),
    .mem_we_o(we_le), .mem_wdata_o(wd_le), .done_o(done_le), .err_o(err_le)
  );

  store_narrow #(.BIG_ENDIAN(1'b1)) u_be (
    .clk_i(clk), .rst_n(rst_n), .req_i(req), .ready_o(rdy_be),
    .addr_i(addr), .size_i(size), .wdata_i(wdata),
    .mem_addr_o(maddr_be), .mem_re_o(re_be), .mem_rdata_i(rdata_be),
    .mem_we_o(we_be), .mem_wdata_o(wd_be), .done_o(done_be), .err_o(err_be)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: read data one cycle after the strobe, full-word writes.
  always @(posedge clk) begin
    if (re_le) rdata_le <= dmem_le[maddr_le[9:2]];
    if (re_be) rdata_be <= dmem_be[maddr_be[9:2]];
    if (we_le) dmem_le[maddr_le[9:2]] = wd_le;
    if (we_be) dmem_be[maddr_be[9:2]] = wd_be;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe exclusivity holds every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl_le", {30'b0, re_le & we_le, done_le & err_le}, 32'h0);
      chk("excl_be", {30'b0, re_be & we_be, done_be & err_be}, 32'h0);
    end
  end

  // Reference: old word with the addressed lane(s) replaced by narrowed data.
  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] a,
                                            input logic [1:0] s, input logic [31:0] d,
                                            input bit be);
    int unsigned k, h, sh;
    logic [31:0] m;
    k = a[1:0];
    h = a[1];
    if (s == 2'b10) return d;
    if (s == 2'b00) begin
      m  = 32'h0000_00FF;
      sh = be ? 8 * (3 - k) : 8 * k;
    end else begin
      m  = 32'h0000_FFFF;
      sh = be ? 16 * (1 - h) : 16 * h;
    end
    return (old & ~(m << sh)) | ((d & m) << sh);
  endfunction

  task automatic present(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    req   = 1'b1;
    addr  = a;
    size  = s;
    wdata = d;
  endtask

  task automatic idle_inputs();
    req   = 1'b0;
    addr  = $urandom;
    size  = 2'($urandom);
    wdata = $urandom;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    dmem_le[a[9:2]] = v;
    dmem_be[a[9:2]] = v;
    rmem_le[a[9:2]] = v;
    rmem_be[a[9:2]] = v;
  endtask

  // Runs one already-presented store to completion, optionally presenting
  // the next request right after acceptance.
  task automatic follow(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                        input bit nxt, input logic [31:0] na, input logic [1:0] ns,
                        input logic [31:0] nd);
    bit          bad;
    logic [31:0] wa, exp_le, exp_be;
    int unsigned idx;
    bad = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    wa  = {a[31:2], 2'b00};
    idx = a[9:2];
    chk("ready_pre", {30'b0, rdy_le, rdy_be}, 32'h3);
    @(posedge clk); #1;
    if (nxt) present(na, ns, nd); else idle_inputs();
    chk("ready_busy", {30'b0, rdy_le, rdy_be}, 32'h0);
    if (bad) begin
      chk("err_cycle", {24'b0, re_le, we_le, done_le, err_le, re_be, we_be, done_be, err_be},
          32'b0001_0001);
    end else if (s == 2'b10) begin
      chk("word_wr_flags", {24'b0, re_le, we_le, done_le, err_le, re_be, we_be, done_be, err_be},
          32'b0110_0110);
      chk("word_addr_le", maddr_le, wa);
      chk("word_addr_be", maddr_be, wa);
      chk("word_data_le", wd_le, d);
      chk("word_data_be", wd_be, d);
      rmem_le[idx] = d;
      rmem_be[idx] = d;
      last_le = wd_le;
      last_be = wd_be;
    end else begin
      chk("rd_flags", {24'b0, re_le, we_le, done_le, err_le, re_be, we_be, done_be, err_be},
          32'b1000_1000);
      chk("rd_addr_le", maddr_le, wa);
      chk("rd_addr_be", maddr_be, wa);
      @(posedge clk); #1;
      chk("merge_flags", {24'b0, re_le, we_le, done_le, err_le, re_be, we_be, done_be, err_be},
          32'h0);
      exp_le = merge_ref(rmem_le[idx], a, s, d, 1'b0);
      exp_be = merge_ref(rmem_be[idx], a, s, d, 1'b1);
      @(posedge clk); #1;
      chk("wr_flags", {24'b0, re_le, we_le, done_le, err_le, re_be, we_be, done_be, err_be},
          32'b0110_0110);
      chk("wr_addr_le", maddr_le, wa);
      chk("wr_addr_be", maddr_be, wa);
      chk("wr_data_le", wd_le, exp_le);
      chk("wr_data_be", wd_be, exp_be);
      rmem_le[idx] = exp_le;
      rmem_be[idx] = exp_be;
      last_le = wd_le;
      last_be = wd_be;
    end
    @(posedge clk); #1;
    chk("back_idle", {24'b0, rdy_le, done_le, err_le, we_le, rdy_be, done_be, err_be, we_be},
        32'b1000_1000);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      dmem_le[i] = (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_5A5A;
      dmem_be[i] = dmem_le[i];
      rmem_le[i] = dmem_le[i];
      rmem_be[i] = dmem_le[i];
    end
    #2;
    chk("reset_flags", {24'b0, rdy_le, re_le, we_le, done_le, err_le, rdy_be, re_be, we_be},
        32'b1000_0100);
    chk("reset_addr", maddr_le | maddr_be, 32'h0);
    chk("reset_wdata", wd_le | wd_be, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Word store.
    present(32'h100, 2'b10, 32'hDEAD_BEEF);
    follow(32'h100, 2'b10, 32'hDEAD_BEEF, 1'b0, '0, '0, '0);
    chk("word_const", last_le, 32'hDEAD_BEEF);

    // Byte store into a known word.
    set_word(32'h200, 32'h1122_3344);
    present(32'h203, 2'b00, 32'h1234_56AB);
    follow(32'h203, 2'b00, 32'h1234_56AB, 1'b0, '0, '0, '0);
    chk("byte_const_le", last_le, 32'hAB22_3344);
    chk("byte_const_be", last_be, 32'h1122_33AB);

    // Halfword store, upper data bits discarded.
    set_word(32'h300, 32'h1122_3344);
    present(32'h302, 2'b01, 32'hFFFF_CAFE);
    follow(32'h302, 2'b01, 32'hFFFF_CAFE, 1'b0, '0, '0, '0);
    chk("half_const_le", last_le, 32'hCAFE_3344);
    chk("half_const_be", last_be, 32'h1122_CAFE);

    // Rejected requests.
    present(32'h101, 2'b01, 32'h1);
    follow(32'h101, 2'b01, 32'h1, 1'b0, '0, '0, '0);
    present(32'h102, 2'b10, 32'h2);
    follow(32'h102, 2'b10, 32'h2, 1'b0, '0, '0, '0);
    present(32'h100, 2'b11, 32'h3);
    follow(32'h100, 2'b11, 32'h3, 1'b0, '0, '0, '0);

    // Back-to-back byte stores into the same word.
    set_word(32'h3C0, 32'h5566_7788);
    present(32'h3C1, 2'b00, 32'h0000_00A1);
    follow(32'h3C1, 2'b00, 32'h0000_00A1, 1'b1, 32'h3C2, 2'b00, 32'h0000_00B2);
    follow(32'h3C2, 2'b00, 32'h0000_00B2, 1'b0, '0, '0, '0);
    chk("b2b_const_le", last_le, 32'h55B2_A188);
    chk("b2b_const_be", last_be, 32'h55A1_B288);

    // Reset during MERGE aborts the store.
    present(32'h0F1, 2'b00, 32'h0000_0077);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("pre_abort_merge", {30'b0, re_le, we_le}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {24'b0, rdy_le, re_le, we_le, done_le, err_le, rdy_be, re_be, we_be},
        32'b1000_0100);
    chk("abort_addr", maddr_le | maddr_be, 32'h0);
    chk("abort_wdata", wd_le | wd_be, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_abort", {26'b0, rdy_le, we_le, done_le, rdy_be, we_be, done_be}, 32'b100100);
    end

    // Randomized stores, some back-to-back.
    for (int i = 0; i < N; i++) begin
      rs[i] = 2'($urandom_range(0, 3));
      ra[i] = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rs[i] == 2'b01) ra[i][0] = 1'b0;
        if (rs[i] == 2'b10) ra[i][1:0] = 2'b00;
      end
      rd[i]   = $urandom;
      rb2b[i] = ($urandom_range(0, 1) == 1) && (i + 1 < N);
    end
    for (int i = 0; i < N; i++) begin
      if (i == 0 || !rb2b[i-1]) present(ra[i], rs[i], rd[i]);
      if (rb2b[i])
        follow(ra[i], rs[i], rd[i], 1'b1, ra[i+1], rs[i+1], rd[i+1]);
      else
        follow(ra[i], rs[i], rd[i], 1'b0, '0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
